fetch_queue_2way: RTL and testbench

Instruction queue between the dual-port instruction memory and the two decode slots of the 2-way superscalar core. Each cycle it accepts one fetched pair (instr1 at PC, instr2 at PC+4), buffers it in an 8-entry circular queue, and presents the two oldest instructions with their PCs to decode. Decode consumes 0, 1 or 2 instructions per cycle. A branch redirect flushes the queue. Fetch stalls while the queue lacks room for a full pair.

---
 rtl/fetch_queue_2way.sv | 95 +++++++++
 tb/tb_fetch_queue_2way.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fetch_queue_2way.sv
// rtl/fetch_queue_2way.sv - 2-way instruction fetch queue between imem and decode
// Accepts one PC/PC+4 pair per cycle, presents the two oldest entries, flushes on redirect.
module fetch_queue_2way #(
    parameter int DEPTH = 8,
    parameter int XLEN  = 64,
    parameter int ILEN  = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       flush,
    input  logic                       in_valid,
    input  logic [XLEN-1:0]            in_pc,
    input  logic [ILEN-1:0]            in_instr1,
    input  logic [ILEN-1:0]            in_instr2,
    output logic                       in_ready,
    input  logic [1:0]                 deq_cnt,
    output logic                       out_valid0,
    output logic                       out_valid1,
    output logic [ILEN-1:0]            out_instr0,
    output logic [ILEN-1:0]            out_instr1,
    output logic [XLEN-1:0]            out_pc0,
    output logic [XLEN-1:0]            out_pc1,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [XLEN-1:0] pc_mem_q    [DEPTH];
    logic [XLEN-1:0] pc_mem_d    [DEPTH];
    logic [ILEN-1:0] instr_mem_q [DEPTH];
    logic [ILEN-1:0] instr_mem_d [DEPTH];

    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [PW-1:0] tail_p1, head_p1;
    logic [CW-1:0] count_q, count_d;
    logic [1:0]    deq_sat, deq_amt;
    logic          enq;

    always_comb begin
        in_ready = (count_q <= CW'(DEPTH - 2));
        enq      = in_valid & in_ready & ~flush;
        deq_sat  = (deq_cnt == 2'd3) ? 2'd2 : deq_cnt;
        // Overshoot past the occupied entries is clamped, never an error
        deq_amt  = (count_q < CW'(deq_sat)) ? count_q[1:0] : deq_sat;
        tail_p1  = tail_q + PW'(1);

        pc_mem_d    = pc_mem_q;
        instr_mem_d = instr_mem_q;
        if (enq) begin
            pc_mem_d[tail_q]     = in_pc;
            instr_mem_d[tail_q]  = in_instr1;
            pc_mem_d[tail_p1]    = in_pc + XLEN'(4);
            instr_mem_d[tail_p1] = in_instr2;
        end

        head_d  = head_q + PW'(deq_amt);
        tail_d  = enq ? (tail_q + PW'(2)) : tail_q;
        count_d = count_q + (enq ? CW'(2) : CW'(0)) - CW'(deq_amt);

        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Storage is left unreset; invalid slots are gated to zero below
    always_ff @(posedge clk) begin
        pc_mem_q    <= pc_mem_d;
        instr_mem_q <= instr_mem_d;
    end

    always_comb begin
        head_p1    = head_q + PW'(1);
        count      = count_q;
        out_valid0 = (count_q != '0);
        out_valid1 = (count_q >= CW'(2));
        out_pc0    = out_valid0 ? pc_mem_q[head_q]     : '0;
        out_instr0 = out_valid0 ? instr_mem_q[head_q]  : '0;
        out_pc1    = out_valid1 ? pc_mem_q[head_p1]    : '0;
        out_instr1 = out_valid1 ? instr_mem_q[head_p1] : '0;
    end
endmodule

// File: tb/tb_fetch_queue_2way.sv
// tb/tb_fetch_queue_2way.sv - directed and random checks of fetch_queue_2way against a queue model
module tb_fetch_queue_2way;
    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic [63:0] in_pc;
    logic [31:0] in_instr1, in_instr2;
    logic        in_ready;
    logic [1:0]  deq_cnt;
    logic        out_valid0, out_valid1;
    logic [31:0] out_instr0, out_instr1;
    logic [63:0] out_pc0, out_pc1;
    logic [3:0]  count;

    fetch_queue_2way #(.DEPTH(DEPTH), .XLEN(64), .ILEN(32)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush), .in_valid(in_valid),
        .in_pc(in_pc), .in_instr1(in_instr1), .in_instr2(in_instr2),
        .in_ready(in_ready), .deq_cnt(deq_cnt),
        .out_valid0(out_valid0), .out_valid1(out_valid1),
        .out_instr0(out_instr0), .out_instr1(out_instr1),
        .out_pc0(out_pc0), .out_pc1(out_pc1), .count(count)
    );

    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;
    logic [95:0] mq[$];
    logic last_acc;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int n;
        n = mq.size();
        chk({tag, ".count"}, 64'(count), 64'(n));
        chk({tag, ".in_ready"}, 64'(in_ready), 64'(n <= DEPTH - 2));
        chk({tag, ".valid0"}, 64'(out_valid0), 64'(n >= 1));
        chk({tag, ".valid1"}, 64'(out_valid1), 64'(n >= 2));
        chk({tag, ".pc0"}, out_pc0, (n >= 1) ? mq[0][95:32] : 64'd0);
        chk({tag, ".instr0"}, 64'(out_instr0), (n >= 1) ? 64'(mq[0][31:0]) : 64'd0);
        chk({tag, ".pc1"}, out_pc1, (n >= 2) ? mq[1][95:32] : 64'd0);
        chk({tag, ".instr1"}, 64'(out_instr1), (n >= 2) ? 64'(mq[1][31:0]) : 64'd0);
    endtask

    task automatic step(input string tag, input logic f, input logic v, input logic [63:0] pc,
                        input logic [31:0] a, input logic [31:0] b, input logic [1:0] d);
        int n;
        flush = f; in_valid = v; in_pc = pc; in_instr1 = a; in_instr2 = b; deq_cnt = d;
        last_acc = 1'b0;
        if (f) begin
            mq.delete();
        end else begin
            last_acc = v && (mq.size() <= DEPTH - 2);
            n = (d == 2'd3) ? 2 : int'(d);
            if (n > mq.size()) n = mq.size();
            repeat (n) void'(mq.pop_front());
            if (last_acc) begin
                mq.push_back({pc, a});
                mq.push_back({pc + 64'd4, b});
            end
        end
        @(posedge clk);
        @(negedge clk);
        flush = 1'b0; in_valid = 1'b0; deq_cnt = 2'd0;
        check_all(tag);
    endtask

    function automatic logic [31:0] ins(input logic [63:0] pc);
        return pc[31:0] ^ 32'hA5A5_0013;
    endfunction

    initial begin
        logic [63:0] pc_in, next_exp, rpc;
        logic [1:0]  d;
        int n;
        logic alt;

        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; deq_cnt = 2'd0;
        in_pc = '0; in_instr1 = '0; in_instr2 = '0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        check_all("reset");

        // Async reset mid-operation
        step("pre_rst0", 0, 1, 64'h100, 32'h11, 32'h22, 0);
        step("pre_rst1", 0, 1, 64'h108, 32'h33, 32'h44, 0);
        step("pre_rst2", 0, 1, 64'h110, 32'h55, 32'h66, 0);
        chk("pre_rst.count", 64'(count), 64'd6);
        #2 rst_n = 1'b0;
        #1 mq.delete();
        check_all("async_rst");
        #1 rst_n = 1'b1;
        @(negedge clk);
        check_all("post_rst");

        step("single", 0, 1, 64'h0, 32'h015A04B3, 32'h00148493, 0);
        chk("single.pc0", out_pc0, 64'h0);
        chk("single.instr0", 64'(out_instr0), 64'h015A04B3);
        chk("single.pc1", out_pc1, 64'h4);
        chk("single.instr1", 64'(out_instr1), 64'h00148493);
        chk("single.count", 64'(count), 64'd2);

        // Fill and backpressure
        step("fill_flush", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 5; i++) begin
            pc_in = 64'(i * 8);
            step("fill", 0, 1, pc_in, ins(pc_in), ins(pc_in + 4), 0);
        end
        chk("full.count", 64'(count), 64'd8);
        chk("full.in_ready", 64'(in_ready), 64'd0);
        step("drain6", 0, 0, 0, 0, 0, 2);
        step("enq_deq6", 0, 1, 64'h28, ins(64'h28), ins(64'h2C), 2);
        chk("enq_deq6.count", 64'(count), 64'd6);
        step("to5", 0, 0, 0, 0, 0, 1);
        step("to7", 0, 1, 64'h30, ins(64'h30), ins(64'h34), 0);
        chk("at7.in_ready", 64'(in_ready), 64'd0);
        step("at7_deq2", 0, 1, 64'h38, ins(64'h38), ins(64'h3C), 2);
        chk("at7_deq2.count", 64'(count), 64'd5);

        // Wrap and order
        step("wrap_flush", 1, 0, 0, 0, 0, 0);
        pc_in = 0; next_exp = 0; alt = 1'b0;
        for (int cyc = 0; cyc < 80 && (pc_in <= 64'h38 || mq.size() > 0); cyc++) begin
            d = alt ? 2'd2 : 2'd1;
            alt = ~alt;
            n = int'(d);
            if (n > mq.size()) n = mq.size();
            for (int k = 0; k < n; k++) begin
                chk("wrap.order", (k == 0) ? out_pc0 : out_pc1, next_exp);
                next_exp += 64'd4;
            end
            step("wrap", 0, pc_in <= 64'h38, pc_in, ins(pc_in), ins(pc_in + 4), d);
            if (last_acc) pc_in += 64'd8;
        end
        chk("wrap.consumed_all", next_exp, 64'h40);

        // Clamp
        step("clamp_flush", 1, 0, 0, 0, 0, 0);
        step("clamp_a", 0, 1, 64'h200, 32'hAA, 32'hBB, 0);
        step("clamp_b", 0, 0, 0, 0, 0, 1);
        step("clamp_c", 0, 0, 0, 0, 0, 2);
        chk("clamp1.count", 64'(count), 64'd0);
        chk("clamp1.valid0", 64'(out_valid0), 64'd0);
        step("clamp_d", 0, 1, 64'h300, 32'hCC, 32'hDD, 0);
        step("clamp_e", 0, 1, 64'h308, 32'hEE, 32'hFF, 0);
        step("clamp_f", 0, 0, 0, 0, 0, 3);
        chk("clamp3.count", 64'(count), 64'd2);
        chk("clamp3.pc0", out_pc0, 64'h308);

        // Flush priority
        step("fl_prep", 1, 0, 0, 0, 0, 0);
        for (int i = 0; i < 3; i++) begin
            pc_in = 64'h10 + 64'(i * 8);
            step("fl_fill", 0, 1, pc_in, ins(pc_in), ins(pc_in + 4), 0);
        end
        step("flush", 1, 1, 64'h2C, ins(64'h2C), ins(64'h30), 2);
        chk("flush.count", 64'(count), 64'd0);
        step("post_flush", 0, 1, 64'h44, ins(64'h44), ins(64'h48), 0);
        chk("post_flush.pc0", out_pc0, 64'h44);
        chk("post_flush.pc1", out_pc1, 64'h48);

        // PC+4 wraps modulo 2^64
        step("pcwrap", 0, 1, 64'hFFFF_FFFF_FFFF_FFFC, 32'h1, 32'h2, 2);

        // Random traffic
        for (int i = 0; i < 400; i++) begin
            if (i == 200) begin
                #2 rst_n = 1'b0;
                #1 mq.delete();
                check_all("rand_rst");
                #1 rst_n = 1'b1;
                @(negedge clk);
            end
            rpc = ($urandom_range(0, 15) == 0) ? 64'hFFFF_FFFF_FFFF_FFFC : {$urandom, $urandom};
            step("rand", $urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0, rpc,
                 $urandom, $urandom, 2'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
